// File: rtl/uart_rx_n.sv
// Multi-byte UART receiver: 8N1, LSB first. Assembles up to 8 bytes into a
// 64-bit word, with the first byte received in the most significant used byte.
module uart_rx_n #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RX,
  input  logic [3:0]  Num,
  output logic [63:0] Buffer,
  output logic        Valid,
  output logic        FrameErr,
  output logic        Timeout,
  output logic        Busy,
  output logic [3:0]  Count
);

  localparam int GAP_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TICK_W     = $clog2(CLKS_PER_BIT);
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_BREAK
  } state_t;

  state_t state, state_nxt;

  logic              rx_meta, rx_sync, rx_prev;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift_byte, shift_byte_nxt;
  logic [63:0]       acc, acc_nxt;
  logic [3:0]        target, target_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              from_gap, from_gap_nxt;
  logic [63:0]       buffer_nxt;
  logic              valid_nxt, frame_err_nxt, timeout_nxt, busy_nxt;
  logic [3:0]        count_nxt;

  logic        start_edge;
  logic        tick_done;
  logic [63:0] acc_new;
  logic [3:0]  count_inc;

  assign start_edge = rx_prev & ~rx_sync;
  assign tick_done  = (tick == '0);
  assign acc_new    = {acc[55:0], shift_byte};
  assign count_inc  = Count + 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= S_IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      shift_byte <= '0;
      acc        <= '0;
      target     <= 4'd8;
      gap_cnt    <= '0;
      from_gap   <= 1'b0;
      Buffer     <= '0;
      Valid      <= 1'b0;
      FrameErr   <= 1'b0;
      Timeout    <= 1'b0;
      Busy       <= 1'b0;
      Count      <= '0;
    end else begin
      rx_meta    <= RX;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      state      <= state_nxt;
      tick       <= tick_nxt;
      bit_idx    <= bit_idx_nxt;
      shift_byte <= shift_byte_nxt;
      acc        <= acc_nxt;
      target     <= target_nxt;
      gap_cnt    <= gap_cnt_nxt;
      from_gap   <= from_gap_nxt;
      Buffer     <= buffer_nxt;
      Valid      <= valid_nxt;
      FrameErr   <= frame_err_nxt;
      Timeout    <= timeout_nxt;
      Busy       <= busy_nxt;
      Count      <= count_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    tick_nxt       = tick_done ? TICK_FULL : tick - 1'b1;
    bit_idx_nxt    = bit_idx;
    shift_byte_nxt = shift_byte;
    acc_nxt        = acc;
    target_nxt     = target;
    gap_cnt_nxt    = gap_cnt;
    from_gap_nxt   = from_gap;
    buffer_nxt     = Buffer;
    valid_nxt      = 1'b0;
    frame_err_nxt  = 1'b0;
    timeout_nxt    = 1'b0;
    busy_nxt       = Busy;
    count_nxt      = Count;

    unique case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_nxt    = S_START;
          tick_nxt     = TICK_HALF;
          target_nxt   = (Num == 4'd0 || Num > 4'd8) ? 4'd8 : Num;
          acc_nxt      = '0;
          count_nxt    = '0;
          from_gap_nxt = 1'b0;
        end
      end

      S_START: begin
        // A false start from the gap must not restart the inter-byte timer.
        if (from_gap && gap_cnt != '0) gap_cnt_nxt = gap_cnt - 1'b1;
        if (tick_done) begin
          if (rx_sync) begin
            state_nxt = from_gap ? S_GAP : S_IDLE;
          end else begin
            state_nxt   = S_DATA;
            bit_idx_nxt = '0;
            busy_nxt    = 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick_done) begin
          shift_byte_nxt = {rx_sync, shift_byte[7:1]};
          bit_idx_nxt    = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        if (tick_done) begin
          if (!rx_sync) begin
            frame_err_nxt = 1'b1;
            busy_nxt      = 1'b0;
            count_nxt     = '0;
            state_nxt     = S_BREAK;
          end else begin
            acc_nxt   = acc_new;
            count_nxt = count_inc;
            if (count_inc == target) begin
              buffer_nxt = acc_new;
              valid_nxt  = 1'b1;
              busy_nxt   = 1'b0;
              state_nxt  = S_IDLE;
            end else begin
              gap_cnt_nxt = GAP_LOAD;
              state_nxt   = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        if (start_edge) begin
          state_nxt    = S_START;
          tick_nxt     = TICK_HALF;
          from_gap_nxt = 1'b1;
        end else if (gap_cnt == '0) begin
          timeout_nxt = 1'b1;
          busy_nxt    = 1'b0;
          count_nxt   = '0;
          state_nxt   = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end

      S_BREAK: begin
        if (rx_sync) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_n.sv
// Directed bench for uart_rx_n: a message-level model predicts every output
// pulse and the Buffer contents; a per-cycle monitor compares the DUT to it.
module tb_uart_rx_n;

  localparam int CPB      = 16;
  localparam int TMO_BITS = 20;

  logic        Clock;
  logic        Reset;
  logic        RX;
  logic [3:0]  Num;
  logic [63:0] Buffer;
  logic        Valid, FrameErr, Timeout, Busy;
  logic [3:0]  Count;

  uart_rx_n #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TMO_BITS)) dut (
    .Clock(Clock), .Reset(Reset), .RX(RX), .Num(Num),
    .Buffer(Buffer), .Valid(Valid), .FrameErr(FrameErr),
    .Timeout(Timeout), .Busy(Busy), .Count(Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef enum int {EV_VALID, EV_FERR, EV_TMO} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [63:0] word;
  } ev_t;

  ev_t         exp_q[$];
  logic [63:0] model_buf = '0;
  logic [7:0]  tx_bytes[8];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          count_rise_cyc = 0;
  logic [3:0]  prev_count = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] kind_bits(input ev_kind_t k);
    case (k)
      EV_VALID: return 3'b100;
      EV_FERR:  return 3'b010;
      default:  return 3'b001;
    endcase
  endfunction

  always @(posedge Clock) cyc++;

  // Monitor: every pulse must match the next predicted event; Buffer must
  // always equal the last predicted completed message.
  ev_t ev;
  int  pulses;
  always @(negedge Clock) begin
    if (Reset) begin
      model_buf  = '0;
      prev_count = '0;
    end else begin
      pulses = int'(Valid) + int'(FrameErr) + int'(Timeout);
      if (pulses != 0) begin
        check("pulse_exclusive", 64'(pulses), 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'({Valid, FrameErr, Timeout}), 64'd0);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind", 64'({Valid, FrameErr, Timeout}), 64'(kind_bits(ev.kind)));
          if (ev.kind == EV_VALID) model_buf = ev.word;
        end
      end
      check("buffer", Buffer, model_buf);
      if (Count > prev_count) count_rise_cyc = cyc;
      prev_count = Count;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cycles(CPB);
    end
    RX = 1'b1;
    wait_cycles(CPB);
  endtask

  // Model: a message of n bytes yields sum(byte[i] << 8*(n-1-i)).
  task automatic expect_msg(input logic [3:0] num, input int n_send);
    int          n;
    logic [63:0] word;
    n    = (num == 4'd0 || num > 4'd8) ? 8 : int'(num);
    word = '0;
    for (int i = 0; i < n; i++) word = word + (64'(tx_bytes[i]) << (8 * (n - 1 - i)));
    if (n_send == n) exp_q.push_back('{EV_VALID, word});
  endtask

  task automatic send_msg(input logic [3:0] num, input int n_send);
    expect_msg(num, n_send);
    Num = num;
    for (int i = 0; i < n_send; i++) send_byte(tx_bytes[i]);
    wait_cycles(4);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int gap;

    Reset = 1'b1;
    RX    = 1'b1;
    Num   = 4'd3;
    wait_cycles(3);
    check("rst_buffer", Buffer, 64'd0);
    check("rst_pulses", 64'({Valid, FrameErr, Timeout}), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_count", 64'(Count), 64'd0);
    Reset = 1'b0;
    wait_cycles(2 * CPB);

    // 1: three bytes back-to-back; a mid-message Num change is ignored.
    tx_bytes[0] = 8'h41; tx_bytes[1] = 8'h42; tx_bytes[2] = 8'h43;
    expect_msg(4'd3, 3);
    Num = 4'd3;
    send_byte(8'h41);
    check("t1_count1", 64'(Count), 64'd1);
    check("t1_busy_mid", 64'(Busy), 64'd1);
    Num = 4'd1;
    send_byte(8'h42);
    check("t1_count2", 64'(Count), 64'd2);
    send_byte(8'h43);
    wait_cycles(4);
    check("t1_count3", 64'(Count), 64'd3);
    check("t1_busy_end", 64'(Busy), 64'd0);
    check("t1_buffer", Buffer, 64'h0000_0000_0041_4243);
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    wait_cycles(2 * CPB);

    // 2: Num=0 means eight bytes.
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'(i + 1);
    send_msg(4'd0, 8);
    check("t2_buffer", Buffer, 64'h0102_0304_0506_0708);
    check("t2_count", 64'(Count), 64'd8);
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    wait_cycles(2 * CPB);

    // 3: stop bit low, line held low 40 bit-times, then a clean message.
    exp_q.push_back('{EV_FERR, 64'd0});
    Num = 4'd2;
    RX  = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = (8'h55 >> i) & 8'h01;
      wait_cycles(CPB);
    end
    RX = 1'b0;
    wait_cycles(CPB);
    check("t3_busy", 64'(Busy), 64'd0);
    check("t3_count", 64'(Count), 64'd0);
    check("t3_buffer_held", Buffer, 64'h0102_0304_0506_0708);
    check("t3_ferr_drained", 64'(exp_q.size()), 64'd0);
    wait_cycles(40 * CPB);
    RX = 1'b1;
    wait_cycles(2 * CPB);
    tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB;
    send_msg(4'd2, 2);
    check("t3_buffer", Buffer, 64'h0000_0000_0000_AABB);
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    wait_cycles(2 * CPB);

    // 4: one byte then silence; timeout exactly TIMEOUT_BITS bit-times after
    // the stop sample (which is when Count rises).
    exp_q.push_back('{EV_TMO, 64'd0});
    Num = 4'd2;
    send_byte(8'h12);
    seen = 1'b0;
    for (int i = 0; i < 30 * CPB; i++) begin
      @(negedge Clock);
      if (Timeout) begin
        seen = 1'b1;
        break;
      end
    end
    check("t4_timeout_seen", 64'(seen), 64'd1);
    gap = cyc - count_rise_cyc;
    check("t4_timeout_gap", 64'(gap), 64'(TMO_BITS * CPB));
    wait_cycles(1);
    check("t4_count", 64'(Count), 64'd0);
    check("t4_busy", 64'(Busy), 64'd0);
    check("t4_buffer_held", Buffer, 64'h0000_0000_0000_AABB);
    wait_cycles(5 * CPB);
    tx_bytes[0] = 8'h34; tx_bytes[1] = 8'h56;
    send_msg(4'd2, 2);
    check("t4_buffer", Buffer, 64'h0000_0000_0000_3456);
    check("t4_drained", 64'(exp_q.size()), 64'd0);
    wait_cycles(2 * CPB);

    // 5: short glitch in idle is a false start.
    RX = 1'b0;
    wait_cycles(3);
    RX = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge Clock);
      if (Busy) seen = 1'b1;
    end
    check("t5_no_busy", 64'(seen), 64'd0);
    check("t5_count", 64'(Count), 64'd0);
    tx_bytes[0] = 8'h9C;
    send_msg(4'd1, 1);
    check("t5_buffer", Buffer, 64'h0000_0000_0000_009C);
    check("t5_drained", 64'(exp_q.size()), 64'd0);
    wait_cycles(2 * CPB);

    // 6: reset during data bit 4 of the second byte.
    Num = 4'd2;
    send_byte(8'h11);
    RX = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      RX = (8'h22 >> i) & 8'h01;
      wait_cycles(CPB);
    end
    RX = 1'b0;
    wait_cycles(CPB / 2);
    Reset = 1'b1;
    #1;
    check("t6_rst_buffer", Buffer, 64'd0);
    check("t6_rst_outs", 64'({Valid, FrameErr, Timeout, Busy}), 64'd0);
    check("t6_rst_count", 64'(Count), 64'd0);
    wait_cycles(2);
    RX    = 1'b1;
    Reset = 1'b0;
    wait_cycles(2 * CPB);
    tx_bytes[0] = 8'h77; tx_bytes[1] = 8'h88;
    send_msg(4'd2, 2);
    check("t6_buffer", Buffer, 64'h0000_0000_0000_7788);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    wait_cycles(2 * CPB);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
